instruction_fetch: RTL and testbench

//  - Fetch stage feeding the control decoder: holds the PC, requests instruction words from

---
 rtl/instruction_fetch.sv | 90 +++++++++
 tb/tb_instruction_fetch.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC holder and req/ack instruction fetch stage feeding decode (optional fetch timeout under IF_TIMEOUT_EN).
//   Ports: clk, rst (sync, active-high); imem_req/imem_addr/imem_ack/imem_rdata memory handshake;
//   stall from decode; branch_taken/branch_off, jump_en/jump_tgt, jr_en/jr_addr redirects;
//   pc, pc_plus4, instr, opcode, instr_valid to decode; fetch_err sticky timeout flag.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_off,
  input  logic        jump_en,
  input  logic [25:0] jump_tgt,
  input  logic        jr_en,
  input  logic [31:0] jr_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  output logic        fetch_err
);
  typedef enum logic [1:0] {S_RESET, S_FETCH, S_HOLD} state_t;
  state_t state, state_nx;
  logic [31:0] next_pc;
  logic timeout;
  if (TIMEOUT_CYCLES < 1 || RESET_PC[1:0] != 2'b00) begin : g_bad_param
    $error("instruction_fetch: TIMEOUT_CYCLES must be >= 1 and RESET_PC word aligned");
  end
`ifdef IF_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  // Counter only runs while waiting in S_FETCH, so it is already zero on entry.
  assign timeout = state == S_FETCH && !imem_ack && cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      fetch_err <= 1'b0;
    end else begin
      cnt <= (state != S_FETCH || imem_ack) ? '0 : cnt + CW'(1);
      if (timeout) fetch_err <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign fetch_err = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) state <= S_RESET;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state == S_RESET ? S_FETCH :
               state == S_FETCH ? ((imem_ack || timeout) ? S_HOLD : S_FETCH) :
               (stall ? S_HOLD : S_FETCH);
  end
  always_comb begin
    imem_req = state == S_FETCH;
    imem_addr = pc;
    opcode = instr[31:26];
  end
  // Masking rather than slicing keeps JR misalignment handling explicit: low bits are dropped.
  always_comb begin
    next_pc = jr_en        ? (jr_addr & 32'hFFFF_FFFC) :
              jump_en      ? {pc_plus4[31:28], jump_tgt, 2'b00} :
              branch_taken ? pc_plus4 + {{14{branch_off[15]}}, branch_off, 2'b00} :
              pc_plus4;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      pc_plus4 <= RESET_PC + 32'd4;
      instr <= '0;
      instr_valid <= 1'b0;
    end else if (state == S_FETCH && (imem_ack || timeout)) begin
      instr <= imem_ack ? imem_rdata : 32'd0;
      instr_valid <= 1'b1;
    end else if (state == S_HOLD && !stall) begin
      pc <= next_pc;
      pc_plus4 <= next_pc + 32'd4;
      instr_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: scoreboard bench for instruction_fetch with directed redirect/stall/reset vectors.
module tb_instruction_fetch;
  logic clk = 0, rst = 1;
  logic imem_req, imem_ack, stall = 0;
  logic [31:0] imem_addr, imem_rdata;
  logic branch_taken = 0, jump_en = 0, jr_en = 0;
  logic [15:0] branch_off = '0;
  logic [25:0] jump_tgt = '0;
  logic [31:0] jr_addr = '0;
  logic [31:0] pc, pc_plus4, instr;
  logic [5:0] opcode;
  logic instr_valid, fetch_err;
  logic ack_en = 1, ack_force = 0, prev_valid = 0;
  int total = 0, bad = 0;
  typedef struct {logic [31:0] pc; logic [31:0] instr;} exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5C3_0F1E;
  endfunction
  assign imem_ack = ack_force | (imem_req & ack_en);
  assign imem_rdata = mem_word(imem_addr);
  instruction_fetch #(.RESET_PC(32'h0), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .stall(stall), .branch_taken(branch_taken), .branch_off(branch_off),
    .jump_en(jump_en), .jump_tgt(jump_tgt), .jr_en(jr_en), .jr_addr(jr_addr), .pc(pc),
    .pc_plus4(pc_plus4), .instr(instr), .opcode(opcode), .instr_valid(instr_valid), .fetch_err(fetch_err)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask
  always @(negedge clk) begin
    if (instr_valid && !prev_valid) begin
      if (q.size() == 0) chk("sb_unexpected_valid_pc", pc, 32'hXXXX_XXXX);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_pc", pc, e.pc);
        chk("sb_instr", instr, e.instr);
        chk("sb_pc_plus4", pc_plus4, e.pc + 32'd4);
        chk("sb_opcode", {26'b0, opcode}, {26'b0, e.instr[31:26]});
      end
    end
    prev_valid <= instr_valid;
  end
  task automatic wait_valid();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!instr_valid && n < 20);
    if (!instr_valid) chk("wait_valid_timeout", {31'b0, instr_valid}, 32'd1);
  endtask
  task automatic go(input logic [31:0] exp_pc, input logic r, input logic [31:0] ra,
                    input logic j, input logic [25:0] jt, input logic b, input logic [15:0] bo);
    q.push_back('{exp_pc, mem_word(exp_pc)});
    jr_en = r; jr_addr = ra; jump_en = j; jump_tgt = jt; branch_taken = b; branch_off = bo;
    stall = 0;
    @(negedge clk);
    jr_en = 0; jump_en = 0; branch_taken = 0;
    stall = 1;
    wait_valid();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc_plus4", pc_plus4, 32'h4);
    chk("rst_instr", instr, 32'h0);
    chk("rst_opcode", {26'b0, opcode}, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_fetch_err", {31'b0, fetch_err}, 32'd0);
    q.push_back('{32'h0, mem_word(32'h0)});
    q.push_back('{32'h4, mem_word(32'h4)});
    q.push_back('{32'h8, mem_word(32'h8)});
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t1_req", {31'b0, imem_req}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("t1_valid", {31'b0, instr_valid}, (i % 2 == 1) ? 32'd1 : 32'd0);
      if (imem_req) chk("t1_addr", imem_addr, 32'(i * 2));
    end
    stall = 1;
    go(32'h40, 1, 32'h40, 0, 0, 0, 0);
    repeat (3) begin
      @(negedge clk);
      chk("t2_stall_req", {31'b0, imem_req}, 32'd0);
      chk("t2_stall_pc", pc, 32'h40);
      chk("t2_stall_instr", instr, mem_word(32'h40));
      chk("t2_stall_valid", {31'b0, instr_valid}, 32'd1);
    end
    go(32'h44, 0, 0, 0, 0, 0, 0);
    go(32'h100, 1, 32'h100, 0, 0, 0, 0);
    go(32'hFC, 0, 0, 0, 0, 1, 16'hFFFE);
    go(32'h100, 1, 32'h100, 0, 0, 0, 0);
    go(32'h40, 0, 0, 1, 26'h10, 0, 0);
    go(32'h200, 1, 32'h203, 1, 26'h3FF_FFFF, 1, 16'h0100);
    go(32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    go(32'h0, 0, 0, 0, 0, 0, 0);
`ifdef IF_TIMEOUT_EN
    begin
      int reqs = 0;
      ack_en = 0;
      q.push_back('{32'h4, 32'h0});
      stall = 0;
      @(negedge clk);
      stall = 1;
      for (int i = 0; i < 12; i++) begin
        if (instr_valid) break;
        if (imem_req) reqs++;
        @(negedge clk);
      end
      chk("t6_req_cycles", reqs, 32'd4);
      chk("t6_valid", {31'b0, instr_valid}, 32'd1);
      chk("t6_instr_nop", instr, 32'h0);
      chk("t6_fetch_err", {31'b0, fetch_err}, 32'd1);
      ack_en = 1;
      go(32'h8, 0, 0, 0, 0, 0, 0);
      chk("t6_fetch_err_sticky", {31'b0, fetch_err}, 32'd1);
    end
`else
    ack_en = 0;
    q.push_back('{32'h4, mem_word(32'h4)});
    stall = 0;
    @(negedge clk);
    stall = 1;
    repeat (20) @(negedge clk);
    chk("wait_req_held", {31'b0, imem_req}, 32'd1);
    chk("wait_no_valid", {31'b0, instr_valid}, 32'd0);
    chk("wait_fetch_err", {31'b0, fetch_err}, 32'd0);
    ack_en = 1;
    wait_valid();
`endif
    ack_en = 0;
    stall = 0;
    @(negedge clk);
    stall = 1;
    @(negedge clk);
    chk("t5_req_pending", {31'b0, imem_req}, 32'd1);
    rst = 1;
    @(negedge clk);
    chk("t5_req_dropped", {31'b0, imem_req}, 32'd0);
    chk("t5_pc", pc, 32'h0);
    chk("t5_valid", {31'b0, instr_valid}, 32'd0);
    chk("t5_fetch_err", {31'b0, fetch_err}, 32'd0);
    rst = 0;
    ack_force = 1;
    q.push_back('{32'h0, mem_word(32'h0)});
    @(negedge clk);
    ack_force = 0;
    chk("t5_late_ack_ignored", {31'b0, instr_valid}, 32'd0);
    chk("t5_refetch_req", {31'b0, imem_req}, 32'd1);
    chk("t5_refetch_addr", imem_addr, 32'h0);
    ack_en = 1;
    wait_valid();
    @(negedge clk);
    chk("sb_drained", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
